// File: rtl/rle_compressor_if.sv
`default_nettype none
// ============================================================================
// Module      : rle_compressor_if
// Description : Stream handshake bundle for the run-length encoder.
//               Input side carries raw bit words. Output side carries the
//               header word and the run lengths, plus the end-of-stream pulse.
//               The master modport is the producer/sink side, and the slave
//               modport is the encoder side.
// Revision    : 1.0 - initial release
// ============================================================================
interface rle_compressor_if #(
    parameter int DATA_W = 16
) ();
    logic [DATA_W-1:0] in_data;
    logic              in_valid;
    logic              in_last;
    logic              in_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_last;
    logic              out_ready;
    logic              done;

    modport master (
        output in_data, in_valid, in_last, out_ready,
        input  in_ready, out_data, out_valid, out_last, done
    );

    modport slave (
        input  in_data, in_valid, in_last, out_ready,
        output in_ready, out_data, out_valid, out_last, done
    );
endinterface
`default_nettype wire

// File: rtl/rle_compressor.sv
`default_nettype none
// ============================================================================
// Module      : rle_compressor
// Description : Run-length encoder for a bit stream packed into DATA_W-bit
//               words, with bit 0 consumed first. It emits a header word that
//               holds the first bit value. After the header it emits the
//               lengths of the alternating runs. A run longer than MAX_RUN is
//               split with a zero-length run of the opposite value.
//               Optional macro RLE_STATS_EN adds input and output handshake
//               counters.
// Revision    : 1.0 - initial release
// ============================================================================
module rle_compressor #(
    parameter int DATA_W = 16,
    parameter int RUN_W  = 16
) (
    input  wire logic            clk,
    input  wire logic            rst,
    rle_compressor_if.slave      bus
`ifdef RLE_STATS_EN
    ,
    output logic [31:0]          stat_in_words,
    output logic [31:0]          stat_out_words
`endif
);

    localparam int               c_IDX_W   = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [RUN_W-1:0] c_MAX_RUN = '1;

    localparam logic [2:0] c_ST_IDLE   = 3'd0;
    localparam logic [2:0] c_ST_HEADER = 3'd1;
    localparam logic [2:0] c_ST_SHIFT  = 3'd2;
    localparam logic [2:0] c_ST_SPLIT  = 3'd3;
    localparam logic [2:0] c_ST_FETCH  = 3'd4;
    localparam logic [2:0] c_ST_FLUSH  = 3'd5;

    logic [2:0]         r_state;
    logic [DATA_W-1:0]  r_sreg;
    logic               r_last_q;
    logic               r_cur_bit;
    logic [RUN_W-1:0]   r_run;
    logic [c_IDX_W-1:0] r_bit_idx;
    logic [DATA_W-1:0]  r_out_data;
    logic               r_out_valid;
    logic               r_out_last;
    logic               r_done;

    logic               w_free;
    logic               w_in_ready;
    logic               w_in_fire;
    logic               w_out_fire;
    logic               w_bit;
    logic               w_last_bit;
    logic [2:0]         w_adv_state;
    logic [c_IDX_W-1:0] w_adv_idx;

    // The output slot can take a new word when it is empty or is draining this cycle.
    assign w_free      = !r_out_valid | bus.out_ready;
    assign w_in_ready  = (r_state == c_ST_IDLE) | (r_state == c_ST_FETCH);
    assign w_in_fire   = bus.in_valid & w_in_ready;
    assign w_out_fire  = r_out_valid & bus.out_ready;
    assign w_bit       = r_sreg[r_bit_idx];
    assign w_last_bit  = (r_bit_idx == c_IDX_W'(DATA_W - 1));
    // Where a consumed bit leads: the next bit, or the end of the word.
    assign w_adv_state = w_last_bit ? (r_last_q ? c_ST_FLUSH : c_ST_FETCH) : c_ST_SHIFT;
    assign w_adv_idx   = w_last_bit ? r_bit_idx : r_bit_idx + c_IDX_W'(1);

    assign bus.in_ready  = w_in_ready;
    assign bus.out_data  = r_out_data;
    assign bus.out_valid = r_out_valid;
    assign bus.out_last  = r_out_last;
    assign bus.done      = r_done;

    // Encoder FSM and the single registered output slot.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= c_ST_IDLE;
            r_sreg      <= '0;
            r_last_q    <= 1'b0;
            r_cur_bit   <= 1'b0;
            r_run       <= '0;
            r_bit_idx   <= '0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_out_fire) begin
                r_out_valid <= 1'b0;
            end
            case (r_state)
                c_ST_IDLE: begin
                    if (w_in_fire) begin
                        r_sreg    <= bus.in_data;
                        r_last_q  <= bus.in_last;
                        r_cur_bit <= bus.in_data[0];
                        r_run     <= '0;
                        r_bit_idx <= '0;
                        r_state   <= c_ST_HEADER;
                    end
                end
                c_ST_HEADER: begin
                    if (w_free) begin
                        r_out_data  <= DATA_W'(r_cur_bit);
                        r_out_valid <= 1'b1;
                        r_out_last  <= 1'b0;
                        r_state     <= c_ST_SHIFT;
                    end
                end
                c_ST_SHIFT: begin
                    if (w_bit == r_cur_bit) begin
                        if (r_run != c_MAX_RUN) begin
                            r_run     <= r_run + RUN_W'(1);
                            r_bit_idx <= w_adv_idx;
                            r_state   <= w_adv_state;
                        end else if (w_free) begin
                            // A saturated run is closed first. The current bit stays unconsumed.
                            r_out_data  <= DATA_W'(c_MAX_RUN);
                            r_out_valid <= 1'b1;
                            r_out_last  <= 1'b0;
                            r_run       <= '0;
                            r_state     <= c_ST_SPLIT;
                        end
                    end else if (w_free) begin
                        r_out_data  <= DATA_W'(r_run);
                        r_out_valid <= 1'b1;
                        r_out_last  <= 1'b0;
                        r_cur_bit   <= w_bit;
                        r_run       <= RUN_W'(1);
                        r_bit_idx   <= w_adv_idx;
                        r_state     <= w_adv_state;
                    end
                end
                c_ST_SPLIT: begin
                    // A zero-length run of the opposite value keeps the alternation intact.
                    if (w_free) begin
                        r_out_data  <= '0;
                        r_out_valid <= 1'b1;
                        r_out_last  <= 1'b0;
                        r_state     <= c_ST_SHIFT;
                    end
                end
                c_ST_FETCH: begin
                    if (w_in_fire) begin
                        r_sreg    <= bus.in_data;
                        r_last_q  <= bus.in_last;
                        r_bit_idx <= '0;
                        r_state   <= c_ST_SHIFT;
                    end
                end
                c_ST_FLUSH: begin
                    // The final run goes out once. The block then waits for its handshake.
                    if (r_out_valid && r_out_last) begin
                        if (bus.out_ready) begin
                            r_done  <= 1'b1;
                            r_state <= c_ST_IDLE;
                        end
                    end else if (w_free) begin
                        r_out_data  <= DATA_W'(r_run);
                        r_out_valid <= 1'b1;
                        r_out_last  <= 1'b1;
                    end
                end
                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

`ifdef RLE_STATS_EN
    logic [31:0] r_stat_in;
    logic [31:0] r_stat_out;

    // Free-running handshake counters. They wrap naturally at 2**32.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stat_in  <= '0;
            r_stat_out <= '0;
        end else begin
            if (w_in_fire) begin
                r_stat_in <= r_stat_in + 32'd1;
            end
            if (w_out_fire) begin
                r_stat_out <= r_stat_out + 32'd1;
            end
        end
    end

    assign stat_in_words  = r_stat_in;
    assign stat_out_words = r_stat_out;
`endif

endmodule
`default_nettype wire

// File: tb/tb_rle_compressor.sv
`default_nettype none
// ============================================================================
// Module      : tb_rle_compressor
// Description : Scoreboard bench for rle_compressor. It drives one instance
//               with RUN_W=16 and one with RUN_W=4. Expected words are queued
//               when stimulus is issued. A negedge monitor pops and compares
//               each output handshake. Define RLE_STATS_EN to build and check
//               the counters.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rle_compressor;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    rle_compressor_if #(.DATA_W(16)) bus0 ();
    rle_compressor_if #(.DATA_W(16)) bus1 ();

    logic [15:0] drv_data  [2];
    logic        drv_valid [2];
    logic        drv_last  [2];
    logic        drv_ready [2];
    int          rdy_mode  [2];   // 0 always ready, 1 random, 2 held low

    assign bus0.in_data   = drv_data[0];
    assign bus0.in_valid  = drv_valid[0];
    assign bus0.in_last   = drv_last[0];
    assign bus0.out_ready = drv_ready[0];
    assign bus1.in_data   = drv_data[1];
    assign bus1.in_valid  = drv_valid[1];
    assign bus1.in_last   = drv_last[1];
    assign bus1.out_ready = drv_ready[1];

`ifdef RLE_STATS_EN
    logic [31:0] s_in0, s_out0, s_in1, s_out1;
`endif

    rle_compressor #(.DATA_W(16), .RUN_W(16)) u_dut0 (
        .clk (clk),
        .rst (rst),
        .bus (bus0)
`ifdef RLE_STATS_EN
        ,
        .stat_in_words  (s_in0),
        .stat_out_words (s_out0)
`endif
    );

    rle_compressor #(.DATA_W(16), .RUN_W(4)) u_dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
`ifdef RLE_STATS_EN
        ,
        .stat_in_words  (s_in1),
        .stat_out_words (s_out1)
`endif
    );

    logic [16:0] q0[$];
    logic [16:0] q1[$];
    int          done_cnt [2];
    int          done_exp [2];
    logic        hold_p   [2];
    logic [16:0] hold_v   [2];
    logic [15:0] stim     [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Snapshot {done, in_ready, out_valid, out_last, out_data[15:0]}
    function automatic logic [19:0] snap(input int d);
        if (d == 0)
            return {bus0.done, bus0.in_ready, bus0.out_valid, bus0.out_last, bus0.out_data};
        else
            return {bus1.done, bus1.in_ready, bus1.out_valid, bus1.out_last, bus1.out_data};
    endfunction

    function automatic int qsize(input int d);
        return (d == 0) ? q0.size() : q1.size();
    endfunction

    task automatic exp_push(input int d, input logic [15:0] data, input logic last);
        if (d == 0) q0.push_back({last, data});
        else        q1.push_back({last, data});
    endtask

    // Reference: split the bit stream into maximal runs. A run longer than
    // the maximum becomes MAX, 0, MAX, 0, ... and then the remainder.
    task automatic emit_run(input int d, input int len, input logic last, input int maxr);
        int l = len;
        while (l > maxr) begin
            exp_push(d, 16'(maxr), 1'b0);
            exp_push(d, 16'd0, 1'b0);
            l -= maxr;
        end
        exp_push(d, 16'(l), last);
    endtask

    task automatic model(input int d, input int n, input int run_w);
        int   maxr = (1 << run_w) - 1;
        logic cur;
        logic bv;
        logic [15:0] w;
        int   len = 0;
        w   = stim[0];
        cur = w[0];
        exp_push(d, {15'd0, cur}, 1'b0);
        for (int i = 0; i < n; i++) begin
            w = stim[i];
            for (int b = 0; b < 16; b++) begin
                bv = w[b];
                if (bv == cur) len++;
                else begin
                    emit_run(d, len, 1'b0, maxr);
                    cur = bv;
                    len = 1;
                end
            end
        end
        emit_run(d, len, 1'b1, maxr);
    endtask

    // The caller is at posedge+1. The task returns at posedge+1 after the accept.
    task automatic push_word(input int d, input logic [15:0] w, input logic last);
        int guard = 0;
        logic [19:0] s;
        drv_data[d]  = w;
        drv_last[d]  = last;
        drv_valid[d] = 1'b1;
        forever begin
            @(negedge clk);
            s = snap(d);
            if (s[18]) begin
                @(posedge clk);
                #1;
                break;
            end
            guard++;
            if (guard > 5000) begin
                check("in_accept_timeout", 32'd0, 32'd1);
                break;
            end
        end
        drv_valid[d] = 1'b0;
        drv_last[d]  = 1'b0;
    endtask

    task automatic send_stream(input int d, input int n);
        done_exp[d]++;
        for (int i = 0; i < n; i++) push_word(d, stim[i], (i == n - 1));
    endtask

    task automatic wait_idle(input int d, input string name);
        int guard = 0;
        while ((qsize(d) > 0 || done_cnt[d] < done_exp[d]) && guard < 20000) begin
            @(negedge clk);
            guard++;
        end
        repeat (3) @(negedge clk);
        check({name, "_drained"}, qsize(d), 0);
        check({name, "_done"}, done_cnt[d], done_exp[d]);
        @(posedge clk);
        #1;
    endtask

    // Output-ready driver, updated just after each rising edge.
    always @(posedge clk) begin
        #1;
        for (int d = 0; d < 2; d++) begin
            if (rdy_mode[d] == 0)      drv_ready[d] = 1'b1;
            else if (rdy_mode[d] == 1) drv_ready[d] = ($urandom_range(0, 2) != 0);
            else                       drv_ready[d] = 1'b0;
        end
    end

    task automatic mon(input int d);
        logic [19:0] s;
        logic [16:0] e;
        s = snap(d);
        if (hold_p[d]) begin
            check($sformatf("hold_valid%0d", d), {31'd0, s[17]}, 32'd1);
            check($sformatf("hold_word%0d", d), {15'd0, s[16:0]}, {15'd0, hold_v[d]});
        end
        if (s[19]) done_cnt[d]++;
        if (s[17] && drv_ready[d]) begin
            if (qsize(d) == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_out%0d: got 0x%0h with no word expected", d, s[16:0]);
            end else begin
                e = (d == 0) ? q0.pop_front() : q1.pop_front();
                check($sformatf("out%0d", d), {15'd0, s[16:0]}, {15'd0, e});
            end
        end
        hold_p[d] = s[17] && !drv_ready[d];
        hold_v[d] = s[16:0];
    endtask

    // Scoreboard monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (rst) begin
            hold_p[0] = 1'b0;
            hold_p[1] = 1'b0;
        end else begin
            mon(0);
            mon(1);
        end
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [19:0] s;
        int guard;
        for (int d = 0; d < 2; d++) begin
            drv_data[d] = '0; drv_valid[d] = 1'b0; drv_last[d] = 1'b0;
            drv_ready[d] = 1'b1; rdy_mode[d] = 0;
            done_cnt[d] = 0; done_exp[d] = 0; hold_p[d] = 1'b0; hold_v[d] = '0;
        end
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            s = snap(d);
            check($sformatf("rst_out_data%0d", d), {16'd0, s[15:0]}, 32'd0);
            check($sformatf("rst_out_last%0d", d), {31'd0, s[16]}, 32'd0);
            check($sformatf("rst_out_valid%0d", d), {31'd0, s[17]}, 32'd0);
            check($sformatf("rst_in_ready%0d", d), {31'd0, s[18]}, 32'd1);
            check($sformatf("rst_done%0d", d), {31'd0, s[19]}, 32'd0);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Case 1: 00FF, last word
        exp_push(0, 16'h0001, 0); exp_push(0, 16'h0008, 0); exp_push(0, 16'h0008, 1);
        stim[0] = 16'h00FF;
        send_stream(0, 1);
        wait_idle(0, "case1");

        // Case 2: two zero words
        exp_push(0, 16'h0000, 0); exp_push(0, 16'h0020, 1);
        stim[0] = 16'h0000; stim[1] = 16'h0000;
        send_stream(0, 2);
        wait_idle(0, "case2");

        // Case 3: alternating bits
        exp_push(0, 16'h0000, 0);
        for (int i = 0; i < 16; i++) exp_push(0, 16'h0001, (i == 15));
        stim[0] = 16'hAAAA;
        send_stream(0, 1);
        wait_idle(0, "case3");

        // Case 4: case 1 with the sink stalled for 10 cycles once the header shows
        rdy_mode[0] = 2;
        @(posedge clk);
        #1;
        exp_push(0, 16'h0001, 0); exp_push(0, 16'h0008, 0); exp_push(0, 16'h0008, 1);
        stim[0] = 16'h00FF;
        send_stream(0, 1);
        guard = 0;
        do begin
            @(negedge clk);
            s = snap(0);
            guard++;
        end while (!s[17] && guard < 100);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            s = snap(0);
            if (c == 0 || c == 9) begin
                check("stall_out_data", {16'd0, s[15:0]}, 32'h1);
                check("stall_in_ready", {31'd0, s[18]}, 32'd0);
            end
        end
        rdy_mode[0] = 0;
        wait_idle(0, "case4");

        // Case 5: a saturating run on the RUN_W=4 instance
        exp_push(1, 16'h0000, 0); exp_push(1, 16'h000F, 0);
        exp_push(1, 16'h0000, 0); exp_push(1, 16'h0001, 1);
        stim[0] = 16'h0000;
        send_stream(1, 1);
        wait_idle(1, "case5");

        // Randomized streams against the reference model, with a random sink
        for (int d = 0; d < 2; d++) begin
            rdy_mode[d] = 1;
            for (int t = 0; t < 15; t++) begin
                int n;
                n = $urandom_range(1, 4);
                for (int i = 0; i < n; i++) begin
                    case ($urandom_range(0, 3))
                        0:       stim[i] = 16'h0000;
                        1:       stim[i] = 16'hFFFF;
                        default: stim[i] = 16'($urandom);
                    endcase
                end
                model(d, n, (d == 0) ? 16 : 4);
                send_stream(d, n);
                wait_idle(d, $sformatf("rand%0d_%0d", d, t));
            end
            rdy_mode[d] = 0;
        end

        // Case 6: reset while case 3 is mid-SHIFT, then a clean case 1
        @(posedge clk);
        #1;
        exp_push(0, 16'h0000, 0);
        for (int i = 0; i < 16; i++) exp_push(0, 16'h0001, (i == 15));
        push_word(0, 16'hAAAA, 1'b1);
        repeat (4) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        s = snap(0);
        check("midrst_out_valid", {31'd0, s[17]}, 32'd0);
        check("midrst_in_ready", {31'd0, s[18]}, 32'd1);
`ifdef RLE_STATS_EN
        check("midrst_stat_in", s_in0, 32'd0);
        check("midrst_stat_out", s_out0, 32'd0);
`endif
        q0.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        exp_push(0, 16'h0001, 0); exp_push(0, 16'h0008, 0); exp_push(0, 16'h0008, 1);
        stim[0] = 16'h00FF;
        send_stream(0, 1);
        wait_idle(0, "case6");
`ifdef RLE_STATS_EN
        check("stat_in_words", s_in0, 32'd1);
        check("stat_out_words", s_out0, 32'd3);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
